lbdr_output_arbiter: RTL
========================

Name: lbdr_output_arbiter

Overview:
- Output-port side of the router, and the consumer of the per-input LBDR port requests.
- One instance per output port (N, E, W, S, L). It collects the 5 request bits aimed at this port (one per input port), picks one input by round-robin, and holds that grant from HEADER through TAIL (wormhole lock).
- Drives the crossbar column mux and the FIFO read enables, and forwards flits downstream under credit-based flow control.

Parameters:
- FLIT_W, 32, flit width in bits; flit_id occupies bits [FLIT_W-1 -: 3].
- BUF_DEPTH, 4, downstream input-buffer depth; initial credit count.
- CRED_W, 3, credit counter width; must satisfy 2^CRED_W > BUF_DEPTH.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous, active-low reset.
- req, input, 5, request for this output port from each input's LBDR. Index 0=N, 1=E, 2=W, 3=S, 4=L.
- empty, input, 5, per-input FIFO empty flag.
- data_in, input, 5*FLIT_W, FWFT head flit of each input FIFO; input i occupies bits [i*FLIT_W +: FLIT_W].
- credit_in, input, 1, one-cycle pulse; downstream freed one slot.
- rd_en, output, 5, one-hot pop to the granted input FIFO.
- grant, output, 5, one-hot current owner; 0 when idle.
- data_out, output, FLIT_W, registered forwarded flit.
- valid_out, output, 1, data_out valid this cycle.
- credit_err, output, 1, sticky flag: credit overflow observed.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - grant=0, rd_en=0, data_out=0, valid_out=0, credit_err=0.
  - credit_cnt=BUF_DEPTH, state=IDLE, rr_ptr=4, so N has top priority first.
- Flit ids come from the shared package: HEADER, PAYLOAD, TAIL. data_in is valid whenever the matching empty bit is 0.
- State IDLE:
  - Candidates are inputs i with req[i]=1, empty[i]=0 and head flit_id==HEADER.
  - Winner is the first candidate searching rr_ptr+1, rr_ptr+2, … modulo 5.
  - At the next edge: grant <= onehot(winner), state <= LOCKED.
  - With no candidate, stay in IDLE.
- State LOCKED, owner g:
  - rd_en[g] = !empty[g] && credit_cnt != 0. This is combinational from the registered grant, state and credit_cnt; all other rd_en bits are 0.
  - On an edge with rd_en[g]=1: data_out <= data_in[g], valid_out <= 1. Otherwise valid_out <= 0 and data_out holds.
  - If the popped flit's id==TAIL: at the same edge state <= IDLE, grant <= 0, rr_ptr <= g.
  - req, and requests from other inputs, are ignored while LOCKED. Owner req dropping mid-packet does not release the lock.
- Latency:
  - Header visible with req at edge t → grant at t+1.
  - rd_en asserts in cycle t+1 → flit on data_out at t+2.
  - Steady-state throughput is 1 flit/cycle while credits remain.
  - After a TAIL, IDLE needs 1 cycle before the next grant, giving a 1-cycle bubble between packets.
- Credits:
  - Pop alone: credit_cnt - 1. credit_in alone: credit_cnt + 1.
  - Pop and credit_in in the same cycle: unchanged.
  - credit_cnt==0 blocks rd_en; the grant is kept.
  - credit_in while credit_cnt==BUF_DEPTH and no pop: count saturates and credit_err <= 1, held until reset.
- Owner FIFO going empty mid-packet: lock held, rd_en=0, valid_out=0 (bubble).
- Non-HEADER flit at a requesting input in IDLE: that input is not a candidate.
- A reset in the middle of a packet drops the lock and restores all reset values immediately. The partial packet is abandoned; recovery is the upstream's responsibility.

Decomposition:
- Shared package (parameters include): flit_id constants HEADER/PAYLOAD/TAIL, port index constants N=0, E=1, W=2, S=3, L=4, NUM_PORTS=5, and the state enum {IDLE, LOCKED}.
- One sub-module, rr_arbiter5: combinational round-robin pick of a 5-bit candidate vector given rr_ptr; returns a one-hot winner and a found flag.
- The lock FSM, credit counter and output mux stay in the top.

Test Plan:
- After reset, E presents HEADER,PAYLOAD,TAIL with req[1]=1 → grant=5'b00010 at the next edge. data_out carries the 3 flits on consecutive cycles starting 2 cycles after the request, credit_cnt goes 4→1, and grant returns to 0 after TAIL.
- N and L request headers in the same cycle after reset → N wins first (rr_ptr=4). After N's tail, L is granted, then N again if it re-requests.
- BUF_DEPTH=4, 6-flit packet from W, no credit_in → 4 flits forwarded, then rd_en=0 with grant held. One credit_in pulse → exactly one more flit forwarded.
- credit_in pulses in the same cycles as pops → credit_cnt stays constant. An extra credit_in at credit_cnt=4 → credit_err=1, sticky.
- While S is locked mid-packet, E presents a HEADER and S's FIFO goes empty for 2 cycles → 2 bubble cycles with valid_out=0, no grant to E until S's TAIL pops.
- rst driven low mid-packet, asynchronously between edges → grant, rd_en and valid_out are 0 immediately, credit_cnt=4 after release.

Source files
------------

// File: rtl/lbdr_output_arbiter_pkg.sv
// Shared definitions for the LBDR output-port arbiter.
//   - flit_id encodings carried in the top 3 bits of every flit
//   - input port indices and port count
//   - lock FSM state encoding
//   - port_wrap(): modulo-5 "base + step" used by the round-robin search
package lbdr_output_arbiter_pkg;

   localparam int NUM_PORTS = 5;
   localparam int FLIT_ID_W = 3;

   // Input port indices (bit positions in req/empty/grant/rd_en)
   localparam int N = 0;
   localparam int E = 1;
   localparam int W = 2;
   localparam int S = 3;
   localparam int L = 4;

   // flit_id encodings
   localparam logic [FLIT_ID_W-1:0] HEADER  = 3'b001;
   localparam logic [FLIT_ID_W-1:0] PAYLOAD = 3'b010;
   localparam logic [FLIT_ID_W-1:0] TAIL    = 3'b100;

   // Pointer value after reset: the search starts at ptr+1 = N
   localparam logic [2:0] RR_PTR_RESET = 3'd4;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   // (base + step) mod 5 for base in 0..4 and step in 0..5
   function automatic logic [2:0] port_wrap(input logic [2:0] base, input logic [2:0] step);
      logic [3:0] sum_v;
      sum_v = {1'b0, base} + {1'b0, step};
      if (sum_v >= 4'd5) begin
         sum_v = sum_v - 4'd5;
      end else begin
         sum_v = sum_v;
      end
      return sum_v[2:0];
   endfunction

endpackage

// File: rtl/lbdr_output_arbiter_rr.sv
// rr_arbiter5: combinational round-robin pick among 5 candidates.
//   cand   : candidate vector, bit i = input i may be granted
//   rr_ptr : index of the last winner; search starts at rr_ptr+1 (mod 5)
//   winner : one-hot first candidate found, 0 if none
//   found  : at least one candidate present
module rr_arbiter5
   import lbdr_output_arbiter_pkg::*;
(
   input  logic [NUM_PORTS-1:0] cand,
   input  logic [2:0]           rr_ptr,
   output logic [NUM_PORTS-1:0] winner,
   output logic                 found
);

   logic [2:0] idx_s;
   logic       take_s;

   // Walk rr_ptr+1 .. rr_ptr+5; the first hit latches found and blocks later hits.
   always_comb begin
      winner = 5'b00000;
      found  = 1'b0;
      idx_s  = 3'd0;
      take_s = 1'b0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         idx_s         = port_wrap(rr_ptr, 3'(k));
         take_s        = !found && cand[idx_s];
         winner[idx_s] = winner[idx_s] | take_s;
         found         = found | take_s;
      end
   end

endmodule

// File: rtl/lbdr_output_arbiter.sv
// lbdr_output_arbiter: output-port arbiter with wormhole lock and credit flow control.
//   clk, rst     : clock, asynchronous active-low reset
//   req[4:0]     : per-input request for this output (0=N,1=E,2=W,3=S,4=L)
//   empty[4:0]   : per-input FIFO empty flags
//   data_in      : FWFT head flit of each input FIFO, input i at [i*FLIT_W +: FLIT_W]
//   credit_in    : one-cycle pulse, downstream freed a slot
//   rd_en[4:0]   : one-hot pop of the owner FIFO (combinational from registered state)
//   grant[4:0]   : one-hot owner, 0 when idle
//   data_out     : registered forwarded flit
//   valid_out    : data_out carries a new flit this cycle
//   credit_err   : sticky credit-overflow flag
module lbdr_output_arbiter
   import lbdr_output_arbiter_pkg::*;
#(
   parameter int FLIT_W    = 32,
   parameter int BUF_DEPTH = 4,
   parameter int CRED_W    = 3
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        req,
   input  logic [NUM_PORTS-1:0]        empty,
   input  logic [NUM_PORTS*FLIT_W-1:0] data_in,
   input  logic                        credit_in,
   output logic [NUM_PORTS-1:0]        rd_en,
   output logic [NUM_PORTS-1:0]        grant,
   output logic [FLIT_W-1:0]           data_out,
   output logic                        valid_out,
   output logic                        credit_err
);

   localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(BUF_DEPTH);
   localparam logic [CRED_W-1:0] CRED_ONE  = {{(CRED_W-1){1'b0}}, 1'b1};
   localparam logic [CRED_W-1:0] CRED_ZERO = {CRED_W{1'b0}};

   state_e                 state_r, state_nxt_s;
   logic [NUM_PORTS-1:0]   grant_r, grant_nxt_s;
   logic [2:0]             rr_ptr_r, rr_ptr_nxt_s;
   logic [CRED_W-1:0]      credit_cnt_r, credit_nxt_s;
   logic                   credit_err_r, credit_err_nxt_s;
   logic [FLIT_W-1:0]      data_out_r;
   logic                   valid_out_r;

   logic [NUM_PORTS-1:0]   cand_s;
   logic [NUM_PORTS-1:0]   winner_s;
   logic                   found_s;
   logic [FLIT_W-1:0]      owner_flit_s;
   logic [2:0]             owner_idx_s;
   logic                   owner_empty_s;
   logic [NUM_PORTS-1:0]   rd_en_s;
   logic                   pop_s;
   logic                   tail_pop_s;

   // Candidates: requesting, non-empty inputs whose head flit opens a packet.
   always_comb begin
      cand_s = 5'b00000;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand_s[i] = req[i] && !empty[i] &&
                     (data_in[i*FLIT_W + FLIT_W - 1 -: FLIT_ID_W] == HEADER);
      end
   end

   rr_arbiter5 u_rr (
      .cand   (cand_s),
      .rr_ptr (rr_ptr_r),
      .winner (winner_s),
      .found  (found_s)
   );

   // Crossbar column mux: AND-OR select of the owner's head flit and its index.
   always_comb begin
      owner_flit_s = {FLIT_W{1'b0}};
      owner_idx_s  = 3'd0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         owner_flit_s = owner_flit_s | (data_in[i*FLIT_W +: FLIT_W] & {FLIT_W{grant_r[i]}});
         owner_idx_s  = owner_idx_s | (grant_r[i] ? 3'(i) : 3'd0);
      end
   end

   assign owner_empty_s = |(grant_r & empty);

   // Pop the owner whenever it has a flit and downstream has room; grant is kept when blocked.
   always_comb begin
      if ((state_r == LOCKED) && !owner_empty_s && (credit_cnt_r != CRED_ZERO)) begin
         rd_en_s = grant_r;
      end else begin
         rd_en_s = 5'b00000;
      end
   end

   assign pop_s      = |rd_en_s;
   assign tail_pop_s = pop_s && (owner_flit_s[FLIT_W-1 -: FLIT_ID_W] == TAIL);

   // Lock FSM next state: grant a header in IDLE, release on the popped TAIL.
   always_comb begin
      state_nxt_s  = state_r;
      grant_nxt_s  = grant_r;
      rr_ptr_nxt_s = rr_ptr_r;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               state_nxt_s = LOCKED;
               grant_nxt_s = winner_s;
            end else begin
               grant_nxt_s = 5'b00000;
            end
         end
         LOCKED: begin
            if (tail_pop_s) begin
               state_nxt_s  = IDLE;
               grant_nxt_s  = 5'b00000;
               rr_ptr_nxt_s = owner_idx_s;
            end else begin
               state_nxt_s = LOCKED;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            grant_nxt_s = 5'b00000;
         end
      endcase
   end

   // Credit counter next value; a credit at full count with no pop saturates and flags an error.
   always_comb begin
      credit_nxt_s     = credit_cnt_r;
      credit_err_nxt_s = credit_err_r;
      case ({pop_s, credit_in})
         2'b10: begin
            credit_nxt_s = credit_cnt_r - CRED_ONE;
         end
         2'b01: begin
            if (credit_cnt_r == CRED_FULL) begin
               credit_err_nxt_s = 1'b1;
            end else begin
               credit_nxt_s = credit_cnt_r + CRED_ONE;
            end
         end
         default: begin
            credit_nxt_s = credit_cnt_r;
         end
      endcase
   end

   // State, pointer, credit and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         grant_r      <= 5'b00000;
         rr_ptr_r     <= RR_PTR_RESET;
         credit_cnt_r <= CRED_FULL;
         credit_err_r <= 1'b0;
         data_out_r   <= {FLIT_W{1'b0}};
         valid_out_r  <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         grant_r      <= grant_nxt_s;
         rr_ptr_r     <= rr_ptr_nxt_s;
         credit_cnt_r <= credit_nxt_s;
         credit_err_r <= credit_err_nxt_s;
         valid_out_r  <= pop_s;
         if (pop_s) begin
            data_out_r <= owner_flit_s;
         end else begin
            data_out_r <= data_out_r;
         end
      end
   end

   assign rd_en      = rd_en_s;
   assign grant      = grant_r;
   assign data_out   = data_out_r;
   assign valid_out  = valid_out_r;
   assign credit_err = credit_err_r;

endmodule
